// File: rtl/mem_arb_pkg.sv
// Shared types for the main-memory port arbiter.
// States, default line size and index-width helper.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      D_ACC = 2'd1,
      I_ACC = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   localparam int LINE_WORDS_DEF = 4;
   localparam int LINE_IDX_W = $clog2(LINE_WORDS_DEF);

   function automatic int line_idx_w(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: D-side word access
// and I-side line refill, D-side has priority.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int LINE_WORDS = LINE_WORDS_DEF
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 i_req,
   input  logic [ADDR_W-1:0]                    i_addr,
   output logic [DATA_W-1:0]                    i_rdata,
   output logic                                 i_rvalid,
   output logic [line_idx_w(LINE_WORDS)-1:0]    i_word_idx,
   output logic                                 i_done,
   input  logic                                 d_req,
   input  logic                                 d_we,
   input  logic [ADDR_W-1:0]                    d_addr,
   input  logic [DATA_W-1:0]                    d_wdata,
   output logic [DATA_W-1:0]                    d_rdata,
   output logic                                 d_done,
   output logic                                 mem_req,
   output logic                                 mem_we,
   output logic [ADDR_W-1:0]                    mem_addr,
   output logic [DATA_W-1:0]                    mem_wdata,
   input  logic [DATA_W-1:0]                    mem_rdata,
   input  logic                                 mem_ready,
   output logic                                 busy
);

   localparam int IDX_W = line_idx_w(LINE_WORDS);
   localparam logic [ADDR_W-1:0] LINE_MASK =
      ADDR_W'(2 * LINE_WORDS - 1);
   localparam logic [IDX_W-1:0] LAST_IDX =
      IDX_W'(LINE_WORDS - 1);

   arb_state_t        state;
   arb_state_t        state_nxt;
   logic [IDX_W-1:0]  cnt;
   logic [ADDR_W-1:0] line_base;
   logic              d_hit;
   logic              i_hit;
   logic              i_last;

   // d_addr bit 0 is a byte offset inside a word
   logic unused_d_lsb;
   assign unused_d_lsb = d_addr[0];

   assign line_base = i_addr & ~LINE_MASK;
   assign d_hit     = (state == D_ACC) && mem_ready;
   assign i_hit     = (state == I_ACC) && mem_ready;
   assign i_last    = i_hit && (cnt == LAST_IDX);
   assign busy      = (state != IDLE);

   // state register; reset aborts any access in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next state and the combinational memory-side drive
   always_comb begin
      state_nxt = state;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      unique case (state)
         IDLE: begin
            if (d_req)      state_nxt = D_ACC;
            else if (i_req) state_nxt = I_ACC;
         end
         D_ACC: begin
            mem_req   = 1'b1;
            mem_we    = d_we;
            mem_addr  = {d_addr[ADDR_W-1:1], 1'b0};
            mem_wdata = d_wdata;
            if (mem_ready) state_nxt = RESP;
         end
         I_ACC: begin
            mem_req  = 1'b1;
            mem_addr = line_base + ADDR_W'({cnt, 1'b0});
            if (i_last) state_nxt = RESP;
         end
         RESP: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // refill word counter, wraps to 0 after the last word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (i_hit) begin
         if (i_last) cnt <= '0;
         else        cnt <= cnt + IDX_W'(1);
      end
   end

   // registered responses toward the caches
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_rvalid   <= 1'b0;
         i_done     <= 1'b0;
         d_done     <= 1'b0;
         i_rdata    <= '0;
         i_word_idx <= '0;
         d_rdata    <= '0;
      end else begin
         i_rvalid <= i_hit;
         i_done   <= i_last;
         d_done   <= d_hit;
         if (i_hit) begin
            i_rdata    <= mem_rdata;
            i_word_idx <= cnt;
         end
         if (d_hit && !d_we) d_rdata <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: timeline model of
// grants plus directed scenarios with literal checks.
module tb_mem_port_arbiter;

   localparam int LW  = 4;
   localparam int LAT = 3;
   localparam int N   = 1024;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_req = 1'b0;
   logic [15:0] i_addr = '0;
   logic [15:0] i_rdata;
   logic        i_rvalid;
   logic [1:0]  i_word_idx;
   logic        i_done;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [15:0] d_addr = '0;
   logic [15:0] d_wdata = '0;
   logic [15:0] d_rdata;
   logic        d_done;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata = '0;
   logic        mem_ready = 1'b0;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int free_at = 0;
   bit stray = 1'b0;

   logic [15:0] mem [0:32767];
   logic [15:0] ready_q [$];

   logic        e_req   [0:N-1];
   logic        e_we    [0:N-1];
   logic [15:0] e_addr  [0:N-1];
   logic [15:0] e_wd    [0:N-1];
   logic        e_busy  [0:N-1];
   logic        e_rv    [0:N-1];
   logic [1:0]  e_idx   [0:N-1];
   logic [15:0] e_rd    [0:N-1];
   logic        e_idone [0:N-1];
   logic        e_ddone [0:N-1];
   logic        e_dset  [0:N-1];
   logic [15:0] e_dval  [0:N-1];
   logic [15:0] exp_drd = '0;

   mem_port_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_req      (i_req),
      .i_addr     (i_addr),
      .i_rdata    (i_rdata),
      .i_rvalid   (i_rvalid),
      .i_word_idx (i_word_idx),
      .i_done     (i_done),
      .d_req      (d_req),
      .d_we       (d_we),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_rdata    (d_rdata),
      .d_done     (d_done),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] qa(input int i);
      if (i < ready_q.size()) return ready_q[i];
      return 16'hxxxx;
   endfunction

   // memory with fixed latency, grant timeline model, per-cycle compare
   initial begin : model_proc
      int c;
      int lat;
      logic [15:0] base;
      logic [15:0] a;
      lat = 0;
      forever begin
         @(negedge clk);
         c = cyc;
         if (!rst_n) begin
            chk("rst_mem_req", mem_req, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_busy", busy, 0);
            chk("rst_i_rvalid", i_rvalid, 0);
            chk("rst_i_done", i_done, 0);
            chk("rst_i_rdata", i_rdata, 0);
            chk("rst_i_idx", i_word_idx, 0);
            chk("rst_d_done", d_done, 0);
            chk("rst_d_rdata", d_rdata, 0);
            for (int k = c; k < N; k++) begin
               e_req[k] = 0; e_we[k] = 0;
               e_addr[k] = '0; e_wd[k] = '0;
               e_busy[k] = 0; e_rv[k] = 0;
               e_idx[k] = '0; e_rd[k] = '0;
               e_idone[k] = 0; e_ddone[k] = 0;
               e_dset[k] = 0; e_dval[k] = '0;
            end
            free_at = c + 1;
            exp_drd = '0;
            lat = 0;
            mem_ready = 1'b0;
         end else begin
            if (e_dset[c]) exp_drd = e_dval[c];
            chk("mem_req", mem_req, e_req[c]);
            chk("busy", busy, e_busy[c]);
            chk("i_rvalid", i_rvalid, e_rv[c]);
            chk("i_done", i_done, e_idone[c]);
            chk("d_done", d_done, e_ddone[c]);
            chk("d_rdata", d_rdata, exp_drd);
            if (e_req[c]) begin
               chk("mem_we", mem_we, e_we[c]);
               chk("mem_addr", mem_addr, e_addr[c]);
               if (e_we[c]) chk("mem_wdata", mem_wdata, e_wd[c]);
            end
            if (e_rv[c]) begin
               chk("i_rdata", i_rdata, e_rd[c]);
               chk("i_word_idx", i_word_idx, e_idx[c]);
            end
            mem_ready = 1'b0;
            if (mem_req) begin
               lat++;
               if (lat == LAT) begin
                  lat = 0;
                  mem_ready = 1'b1;
                  mem_rdata = mem[mem_addr[15:1]];
                  if (mem_we) mem[mem_addr[15:1]] = mem_wdata;
                  ready_q.push_back(mem_addr);
               end
            end else begin
               lat = 0;
               if (stray) begin
                  mem_ready = 1'b1;
                  mem_rdata = 16'hDEAD;
                  stray = 1'b0;
               end
            end
            if (c >= free_at && c + LW * LAT + 8 < N) begin
               if (d_req) begin
                  for (int k = 1; k <= LAT; k++) begin
                     e_req[c+k]  = 1;
                     e_we[c+k]   = d_we;
                     e_addr[c+k] = {d_addr[15:1], 1'b0};
                     e_wd[c+k]   = d_wdata;
                  end
                  for (int k = 1; k <= LAT + 1; k++) e_busy[c+k] = 1;
                  e_ddone[c+LAT+1] = 1;
                  if (!d_we) begin
                     e_dset[c+LAT+1] = 1;
                     e_dval[c+LAT+1] = mem[d_addr[15:1]];
                  end
                  free_at = c + LAT + 2;
               end else if (i_req) begin
                  base = i_addr & ~16'(2 * LW - 1);
                  for (int w = 0; w < LW; w++) begin
                     a = base + 16'(2 * w);
                     for (int k = 1; k <= LAT; k++) begin
                        e_req[c+w*LAT+k]  = 1;
                        e_we[c+w*LAT+k]   = 0;
                        e_addr[c+w*LAT+k] = a;
                     end
                     e_rv[c+(w+1)*LAT+1]  = 1;
                     e_idx[c+(w+1)*LAT+1] = 2'(w);
                     e_rd[c+(w+1)*LAT+1]  = mem[a[15:1]];
                  end
                  for (int k = 1; k <= LW * LAT + 1; k++)
                     e_busy[c+k] = 1;
                  e_idone[c+LW*LAT+1] = 1;
                  free_at = c + LW * LAT + 2;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string nm,
                            input bit is_i,
                            output int dc);
      dc = -1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         #1;
         if ((is_i && i_done) || (!is_i && d_done)) begin
            dc = cyc;
            break;
         end
      end
      chk({nm, "_seen"}, 32'(dc >= 0), 1);
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin : stim
      int t0;
      int dc;
      int nrv;
      for (int k = 0; k < 32768; k++)
         mem[k] = 16'(k * 257) ^ 16'h5A5A;
      mem[16'h0020] = 16'hBEEF;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy_lit", busy, 0);
      chk("rst_mem_req_lit", mem_req, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      // D read
      ready_q.delete();
      t0 = cyc;
      d_req = 1; d_we = 0; d_addr = 16'h0041;
      wait_done("d_rd", 0, dc);
      chk("d_rd_lat", dc - t0, 4);
      chk("d_rd_data", d_rdata, 16'hBEEF);
      chk("d_rd_nacc", ready_q.size(), 1);
      chk("d_rd_addr", qa(0), 16'h0040);
      tick();
      d_req = 0;
      chk("d_rd_idle", busy, 0);

      // D write
      tick();
      ready_q.delete();
      t0 = cyc;
      d_req = 1; d_we = 1;
      d_addr = 16'h0100; d_wdata = 16'h1234;
      wait_done("d_wr", 0, dc);
      chk("d_wr_lat", dc - t0, 4);
      chk("d_wr_hold", d_rdata, 16'hBEEF);
      chk("d_wr_mem", mem[16'h0080], 16'h1234);
      tick();
      d_req = 0; d_we = 0;

      // stray mem_ready in IDLE is ignored
      stray = 1'b1;
      tick();
      tick();
      chk("stray_busy", busy, 0);
      chk("stray_rv", i_rvalid, 0);

      // I refill
      ready_q.delete();
      t0 = cyc;
      i_req = 1; i_addr = 16'h002A;
      wait_done("i_fill", 1, dc);
      chk("i_fill_lat", dc - t0, 13);
      chk("i_fill_nacc", ready_q.size(), 4);
      chk("i_fill_a0", qa(0), 16'h0028);
      chk("i_fill_a1", qa(1), 16'h002A);
      chk("i_fill_a2", qa(2), 16'h002C);
      chk("i_fill_a3", qa(3), 16'h002E);
      chk("i_fill_idx", i_word_idx, 3);
      tick();
      i_req = 0;

      // contention: D first, then I
      tick();
      t0 = cyc;
      d_req = 1; d_we = 0; d_addr = 16'h0010;
      i_req = 1; i_addr = 16'h0104;
      wait_done("ct_d", 0, dc);
      chk("ct_d_lat", dc - t0, 4);
      tick();
      d_req = 0;
      wait_done("ct_i", 1, dc);
      chk("ct_i_lat", dc - t0, 18);
      tick();
      i_req = 0;

      // wrap at top of address space
      tick();
      ready_q.delete();
      t0 = cyc;
      i_req = 1; i_addr = 16'hFFFE;
      wait_done("wrap", 1, dc);
      chk("wrap_nacc", ready_q.size(), 4);
      chk("wrap_a0", qa(0), 16'hFFF8);
      chk("wrap_a1", qa(1), 16'hFFFA);
      chk("wrap_a2", qa(2), 16'hFFFC);
      chk("wrap_a3", qa(3), 16'hFFFE);
      tick();
      i_req = 0;

      // reset in the middle of a refill
      tick();
      i_req = 1; i_addr = 16'h002A;
      nrv = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         #1;
         if (i_rvalid) nrv++;
         if (nrv == 2) break;
      end
      chk("mr_rv_seen", nrv, 2);
      rst_n = 1'b0;
      #1;
      chk("mr_mem_req", mem_req, 0);
      chk("mr_i_rvalid", i_rvalid, 0);
      chk("mr_busy", busy, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      ready_q.delete();
      t0 = cyc;
      wait_done("mr_fill", 1, dc);
      chk("mr_fill_lat", dc - t0, 13);
      chk("mr_fill_nacc", ready_q.size(), 4);
      chk("mr_fill_a0", qa(0), 16'h0028);
      tick();
      i_req = 0;

      repeat (4) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
